// File: rtl/systolic_feeder_pkg.sv
// Shared sizing defaults and state encoding for the systolic array feeder.
package systolic_feeder_pkg;
  localparam int FEEDER_W = 32;
  localparam int FEEDER_N = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } feeder_state_e;
endpackage

// File: rtl/systolic_feeder_buf.sv
// Block buffer: N entries of {coef, data}. One write port and a read port
// with a registered address. The contents are not reset.
module feeder_buf #(
  parameter int W  = 32,
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [2*W-1:0]  i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [2*W-1:0]  o_rdata
);
  logic [2*W-1:0] r_mem [N];
  logic [AW-1:0]  r_raddr;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_raddr <= i_raddr;
  end

  assign o_rdata = r_mem[r_raddr];
endmodule

// File: rtl/systolic_feeder.sv
// Collects N coef/data pairs and replays them as one gapless burst into a
// systolic array. A job ending in x_last is followed by N zero flush beats and a done pulse.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int W = FEEDER_W,
  parameter int N = FEEDER_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c_valid,
  input  logic [W-1:0] c_data,
  output logic         c_ready,
  input  logic         x_valid,
  input  logic [W-1:0] x_data,
  input  logic         x_last,
  output logic         x_ready,
  output logic [W-1:0] c_out,
  output logic [W-1:0] x_out,
  output logic         s_out,
  output logic         busy,
  output logic         done
);
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  feeder_state_e  r_state, w_state_nxt;
  logic [CW-1:0]  r_wr_cnt, r_rd_cnt, w_rd_cnt_nxt, r_last_idx;
  logic           r_job_last;
  logic [W-1:0]   r_c_out, r_x_out;
  logic           r_s_out, r_done;
  logic           w_fill, w_acc, w_blk_end;
  logic [2*W-1:0] w_rd_data;

  assign w_fill    = (r_state == FILL) && !rst;
  assign c_ready   = w_fill && x_valid;
  assign x_ready   = w_fill && c_valid;
  assign w_acc     = w_fill && c_valid && x_valid;
  assign w_blk_end = w_acc && (x_last || (r_wr_cnt == LAST));

  // Read address is the next rd_cnt so the buffer output lines up with
  // rd_cnt during every BURST cycle.
  feeder_buf #(.W(W), .N(N), .AW(CW)) u_buf (
    .clk     (clk),
    .i_we    (w_acc),
    .i_waddr (r_wr_cnt),
    .i_wdata ({c_data, x_data}),
    .i_raddr (w_rd_cnt_nxt),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_cnt_nxt = r_rd_cnt;
    case (r_state)
      FILL: begin
        w_rd_cnt_nxt = '0;
        if (w_blk_end) w_state_nxt = BURST;
      end
      BURST: begin
        if (r_rd_cnt == LAST) begin
          w_rd_cnt_nxt = '0;
          w_state_nxt  = r_job_last ? FLUSH : FILL;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt + 1'b1;
        end
      end
      FLUSH: begin
        if (r_rd_cnt == LAST) begin
          w_rd_cnt_nxt = '0;
          w_state_nxt  = FILL;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt  = FILL;
        w_rd_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FILL;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_last_idx <= LAST;
      r_job_last <= 1'b0;
      r_c_out    <= '0;
      r_x_out    <= '0;
      r_s_out    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
      r_c_out  <= '0;
      r_x_out  <= '0;
      r_s_out  <= 1'b0;
      r_done   <= 1'b0;
      if (w_acc) begin
        r_wr_cnt <= w_blk_end ? '0 : r_wr_cnt + 1'b1;
        if (x_last)    r_job_last <= 1'b1;
        if (w_blk_end) r_last_idx <= r_wr_cnt;
      end
      // Short-block tail: entries past the last written index read as zero
      // rather than being rewritten through the single write port.
      if (r_state == BURST && r_rd_cnt <= r_last_idx) begin
        r_c_out <= w_rd_data[2*W-1:W];
        r_x_out <= w_rd_data[W-1:0];
        r_s_out <= (r_rd_cnt == '0);
      end
      if (r_state == FLUSH && r_rd_cnt == LAST) begin
        r_done     <= 1'b1;
        r_job_last <= 1'b0;
      end
    end
  end

  assign c_out = r_c_out;
  assign x_out = r_x_out;
  assign s_out = r_s_out;
  assign busy  = (r_state != FILL);
  assign done  = r_done;
endmodule
